// File: rtl/mips_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package mips_fetch_pkg;

  localparam int INSTR_W  = 32;
  localparam int PC_W_DEF = 32;
  localparam logic [PC_W_DEF-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO with push/pop/clear, count and head outputs.
// Latency: a push is visible at head the cycle after; clear wins over push/pop.
// Backpressure: none internally; the caller must not push into a full queue without popping.
module fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int           W       = 64,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock,
  input  logic         Reset,
  input  logic         push,
  input  logic [W-1:0] push_entry,
  input  logic         pop,
  input  logic         clear,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_pop;

  assign do_pop = pop && (count != 2'd0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (Reset) begin
      mem[0] <= RST_VAL;
      mem[1] <= RST_VAL;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(do_pop);
    end
  end

  // The credit scheme upstream guarantees this never happens.
  always_ff @(posedge clock) begin
    if (!Reset) begin
      assert (!(push && !pop && !clear && (count == 2'd2)));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns fetch PC, issues word reads, queues responses, presents one instr/cycle.
// Latency: request accepted at N, response at N+1, instr_valid at N+2; FETCH_ALIGN_CHECK_EN adds misaligned-redirect fault/halt.
// Backpressure: stall holds the queue head; requests are credit-limited to 2 outstanding+queued.
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clock,
  input  logic              Reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fault
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam int     EW        = ADDR_W + INSTR_W;
  localparam entry_t ENTRY_RST = '{pc: RESET_PC, instr: '0};

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] fpc, fpc_nxt;
  logic [ADDR_W-1:0] redir_target;
  logic [ADDR_W-1:0] tag_head;
  logic [1:0]        drop_cnt, drop_nxt;
  logic [1:0]        tag_cnt, q_cnt;
  logic [2:0]        inflight, drop_calc;
  logic              req_fire, consume_fire, rsp_accept, rsp_counted;
  logic              redir_take, redir_bad, fault_q;
  entry_t            q_head, q_push_entry;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redir_target = redirect_pc;

  always_ff @(posedge clock) begin
    if (Reset) begin
      fault_q <= 1'b0;
    end else if (redir_take && redir_bad) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign redir_bad    = 1'b0;
  assign redir_target = redirect_pc & ~ADDR_W'(3);
  assign fault_q      = 1'b0;
`endif

  assign fault = fault_q;

  assign redir_take   = redirect_valid && (state != HALT);
  assign consume_fire = instr_valid && !stall;
  // Slots already promised (in flight or queued) after this cycle's pop.
  assign inflight       = 3'(tag_cnt) + 3'(q_cnt) - 3'(consume_fire);
  assign imem_req_valid = !Reset && (state == FETCH) && (inflight < 3'd2);
  assign imem_req_addr  = fpc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses to requests issued before the last reset are not ours to count.
  assign rsp_counted = imem_rsp_valid && ((tag_cnt != 2'd0) || (drop_cnt != 2'd0));
  assign drop_calc   = 3'(tag_cnt) + 3'(drop_cnt) + 3'(req_fire) - 3'(rsp_counted);
  assign rsp_accept  = imem_rsp_valid && (state == FETCH) && (tag_cnt != 2'd0) && !redirect_valid;

  assign q_push_entry = '{pc: tag_head, instr: imem_rsp_data};

  always_comb begin
    state_nxt = state;
    fpc_nxt   = fpc;
    drop_nxt  = drop_cnt;
    if (req_fire) begin
      fpc_nxt = fpc + ADDR_W'(4);
    end
    if (redir_take) begin
      fpc_nxt  = redir_target;
      drop_nxt = drop_calc[1:0];
      if (drop_calc != 3'd0) begin
        state_nxt = FLUSH;
      end else if (redir_bad || fault_q) begin
        state_nxt = HALT;
      end else begin
        state_nxt = FETCH;
      end
    end else if ((state == FLUSH) && imem_rsp_valid && (drop_cnt != 2'd0)) begin
      drop_nxt = drop_cnt - 2'd1;
      if (drop_cnt == 2'd1) begin
        state_nxt = fault_q ? HALT : FETCH;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state    <= FETCH;
      fpc      <= RESET_PC;
      drop_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      fpc      <= fpc_nxt;
      drop_cnt <= drop_nxt;
    end
  end

  // Issue-order PC tags; a request fired during a redirect is already stale.
  fetch_queue #(
    .W       (ADDR_W),
    .RST_VAL (RESET_PC)
  ) u_tag_q (
    .clock      (clock),
    .Reset      (Reset),
    .push       (req_fire && !redirect_valid),
    .push_entry (fpc),
    .pop        (rsp_accept),
    .clear      (redirect_valid),
    .count      (tag_cnt),
    .head       (tag_head)
  );

  fetch_queue #(
    .W       (EW),
    .RST_VAL (ENTRY_RST)
  ) u_instr_q (
    .clock      (clock),
    .Reset      (Reset),
    .push       (rsp_accept),
    .push_entry (q_push_entry),
    .pop        (consume_fire),
    .clear      (redirect_valid),
    .count      (q_cnt),
    .head       (q_head)
  );

  assign instr_valid = (q_cnt != 2'd0);
  assign instr       = q_head.instr;
  assign instr_pc    = q_head.pc;
  assign pc_plus4    = q_head.pc + ADDR_W'(4);

endmodule
